decred_spi_host: RTL and testbench
==================================

# decred_spi_host

SPI master that drives the miner chip's client-side SPI port (SCSN/SCLK/MOSI in, MISO/IRQ out) from a simple register-request interface. Sits in the host/controller side of the design, or in test harnesses, as the counterpart to the miner's SPI client. Each request performs one 16-bit register frame: one command byte, then one data byte. The block also synchronizes the client's interrupt line.

## Interface
- CLK_DIV, default 4: SCLK half-period in CLK_IN cycles; legal range 1..255.
- CLK_IN  in  1  system clock; all logic on rising edge.
- EXT_RESET_N  in  1  asynchronous, active-low reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  block idle and able to accept a request.
- REQ_WRITE  in  1  1 = register write, 0 = register read.
- REQ_ADDR  in  7  register address.
- REQ_WDATA  in  8  write data; ignored for reads.
- RSP_VALID  out  1  one-cycle pulse when a frame completes.
- RSP_RDATA  out  8  byte shifted in during the data phase; held until the next RSP_VALID.
- SCSN_toClient  out  1  chip select, active low.
- SCLK_toClient  out  1  serial clock, idles low (mode 0).
- MOSI_toClient  out  1  serial data to client.
- MISO_fromClient  in  1  serial data from client.
- IRQ_OUT_fromClient  in  1  asynchronous client interrupt.
- IRQ_SYNC  out  1  IRQ_OUT_fromClient after a 2-flop synchronizer.

## Operation
- Frame = {REQ_WRITE, REQ_ADDR[6:0], REQ_WDATA[7:0]} for writes; the low byte is 0x00 for reads. Transmitted MSB first, 16 bits.
- Request acceptance:
  - Accept on REQ_VALID & REQ_READY; latch the frame.
  - REQ_READY = (state == IDLE), derived combinationally from the state register.
- FSM states: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
  - IDLE: SCSN=1, SCLK=0, MOSI=0.
  - SETUP: SCSN=0, SCLK=0, MOSI=frame[15]; lasts CLK_DIV cycles.
  - SHIFT: 16 bit periods, each consisting of SCLK high for CLK_DIV cycles, then low for CLK_DIV cycles.
    - MISO is sampled in the last cycle of each high half.
    - MOSI advances to the next bit on the cycle SCLK falls.
    - A 5-bit counter tracks the bit periods.
  - HOLD: SCSN=0, SCLK=0; lasts CLK_DIV cycles.
  - GAP: SCSN=1; lasts CLK_DIV cycles. This guarantees the minimum deselect time between frames.
- MISO bits 7..0 (the data phase, bit periods 8..15) shift into RSP_RDATA. Command-phase MISO bits are discarded.
- RSP_VALID pulses on entry to GAP for both reads and writes. RSP_RDATA updates in the same cycle.
- Outputs SCSN, SCLK and MOSI are driven directly from flops; no combinational path to pins.
- A request presented while busy waits; REQ_VALID is not required to stay stable, but only the values present at the accept cycle are used.

## Timing
- Accept at cycle 0; SCSN falls at cycle 1.
- SCSN stays low for (1 + 32 + 1) × CLK_DIV cycles: 136 cycles at CLK_DIV=4.
- RSP_VALID occurs in the cycle SCSN rises.
- REQ_READY reasserts CLK_DIV cycles after RSP_VALID.
- Back-to-back request throughput: one frame per 35 × CLK_DIV + 1 cycles.
- IRQ_SYNC latency: 2 CLK_IN cycles.
- Reset values: SCSN=1, SCLK=0, MOSI=0, RSP_VALID=0, RSP_RDATA=0x00, IRQ_SYNC=0, state IDLE (so REQ_READY=1 once EXT_RESET_N is high).
- Reset asserted mid-frame:
  - Outputs return to reset values immediately (asynchronously).
  - No RSP_VALID is produced.
  - The latched frame is discarded.
- CLK_DIV=1: SCLK = CLK_IN/2; all phase lengths are 1 cycle; the FSM must not skip or duplicate edges.

## Structure
- Package decred_spi_pkg holds:
  - the FSM state enum;
  - FRAME_W=16 and CMD_W=8;
  - the write-flag bit position (15);
  - ADDR_W=7.
- The package is shared with any future SPI client model used in benches.
- Sub-module: decred_sync2, a 2-flop synchronizer with asynchronous active-low reset, used for IRQ. It is reusable for other cross-domain single bits.
- Divider counter (8-bit) and bit counter (5-bit) live in the top module; no further hierarchy.

## Test plan
- Write addr 0x12, data 0xA5, CLK_DIV=4 -> MOSI carries 0x92A5 MSB-first across 16 SCLK rising edges; SCSN low exactly 136 cycles; one RSP_VALID.
- Read addr 0x05, client model returns 0x3C in the data byte -> MOSI=0x0500; RSP_RDATA=0x3C with RSP_VALID in the cycle SCSN rises.
- Two requests held back-to-back -> second SCSN fall exactly 5 cycles (CLK_DIV+1) after the first SCSN rise; no request lost; REQ_READY low throughout each frame.
- Assert EXT_RESET_N low at bit 6 of a write -> SCSN=1, SCLK=0, MOSI=0 in the same cycle; no RSP_VALID; the next request produces a clean full frame.
- CLK_DIV=1, read returning 0xFF then 0x00 -> SCLK period of 2 cycles; exactly 16 rising edges per frame; RSP_RDATA = 0xFF then 0x00.
- Toggle IRQ_OUT_fromClient asynchronously -> IRQ_SYNC follows after 2 cycles; reset forces IRQ_SYNC=0.

Source files
------------

// File: rtl/decred_spi_pkg.sv
// Shared definitions for the Decred miner SPI register protocol (host and client models).
// A frame is {write, addr[6:0], data[7:0]}, shifted MSB first.
package decred_spi_pkg;

  localparam int FRAME_W   = 16;
  localparam int CMD_W     = 8;
  localparam int ADDR_W    = 7;
  localparam int DATA_W    = FRAME_W - CMD_W;
  localparam int WRITE_BIT = 15;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_e;

  // Reads carry a zero data byte on MOSI.
  function automatic logic [FRAME_W-1:0] build_frame(
    input logic              write,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] wdata
  );
    return {write, addr, (write ? wdata : {DATA_W{1'b0}})};
  endfunction

endpackage

// File: rtl/decred_sync2.sv
// Two-flop synchronizer for a single asynchronous bit, asynchronous active-low reset.
module decred_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/decred_spi_host.sv
// SPI mode-0 master issuing one 16-bit register frame per request to the miner's SPI client,
// plus a synchronized copy of the client's interrupt line.
module decred_spi_host
  import decred_spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic              CLK_IN,
  input  logic              EXT_RESET_N,
  // Request handshake: a request is taken on the rising edge where REQ_VALID and
  // REQ_READY are both high; REQ_VALID may drop or change at any other time.
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WRITE,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [DATA_W-1:0] REQ_WDATA,
  output logic              RSP_VALID,
  output logic [DATA_W-1:0] RSP_RDATA,
  output logic              SCSN_toClient,
  output logic              SCLK_toClient,
  output logic              MOSI_toClient,
  input  logic              MISO_fromClient,
  input  logic              IRQ_OUT_fromClient,
  output logic              IRQ_SYNC,
  output logic [2:0]        state_dbg
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [4:0] BIT_LAST = 5'(FRAME_W - 1);

  spi_state_e         state_q, state_d;
  logic [7:0]         div_q, div_d;
  logic [4:0]         bit_q, bit_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0]  rx_q, rx_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               scsn_q, scsn_d;
  logic               sclk_q, sclk_d;
  logic               mosi_q, mosi_d;
  logic               rsp_q, rsp_d;
  logic               phase_end;
  logic [FRAME_W-1:0] req_frame;

  assign phase_end = (div_q == DIV_LAST);
  assign req_frame = build_frame(REQ_WRITE, REQ_ADDR, REQ_WDATA);

  always_ff @(posedge CLK_IN or negedge EXT_RESET_N) begin
    if (!EXT_RESET_N) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      scsn_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      rsp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      scsn_q  <= scsn_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      rsp_q   <= rsp_d;
    end
  end

  // Pin values are computed one cycle ahead so the pins come straight from flops.
  always_comb begin
    state_d = state_q;
    div_d   = div_q + 8'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    scsn_d  = scsn_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    rsp_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        div_d = '0;
        if (REQ_VALID) begin
          state_d = ST_SETUP;
          shift_d = req_frame;
          rx_d    = '0;
          scsn_d  = 1'b0;
          mosi_d  = req_frame[WRITE_BIT];
        end
      end
      ST_SETUP: begin
        if (phase_end) begin
          state_d = ST_SHIFT;
          div_d   = '0;
          bit_d   = '0;
          sclk_d  = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (phase_end) begin
          div_d = '0;
          if (sclk_q) begin
            // End of high half: sample MISO, drop SCLK and present the next bit.
            sclk_d  = 1'b0;
            if (bit_q[3]) begin
              rx_d = {rx_q[DATA_W-2:0], MISO_fromClient};
            end
            shift_d = {shift_q[FRAME_W-2:0], 1'b0};
            mosi_d  = shift_q[FRAME_W-2];
          end else if (bit_q == BIT_LAST) begin
            state_d = ST_HOLD;
          end else begin
            bit_d  = bit_q + 5'd1;
            sclk_d = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (phase_end) begin
          state_d = ST_GAP;
          div_d   = '0;
          scsn_d  = 1'b1;
          mosi_d  = 1'b0;
          rsp_d   = 1'b1;
          rdata_d = rx_q;
        end
      end
      ST_GAP: begin
        if (phase_end) begin
          state_d = ST_IDLE;
          div_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        div_d   = '0;
        scsn_d  = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
      end
    endcase
  end

  assign REQ_READY     = (state_q == ST_IDLE);
  assign RSP_VALID     = rsp_q;
  assign RSP_RDATA     = rdata_q;
  assign SCSN_toClient = scsn_q;
  assign SCLK_toClient = sclk_q;
  assign MOSI_toClient = mosi_q;
  assign state_dbg     = state_q;

  decred_sync2 u_irq_sync (
    .clk   (CLK_IN),
    .rst_n (EXT_RESET_N),
    .d     (IRQ_OUT_fromClient),
    .q     (IRQ_SYNC)
  );

endmodule

// File: tb/tb_decred_spi_host.sv
// Directed bench for decred_spi_host: one instance at CLK_DIV=4 and one at CLK_DIV=1,
// observed one at a time through a select mux, with a simple mode-0 SPI client model.
module tb_decred_spi_host;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_write;
  logic [6:0] req_addr;
  logic [7:0] req_wdata;
  logic       miso;
  logic       irq;
  logic       sel;
  int         cd;

  logic       ready4, rsp4, scsn4, sclk4, mosi4, irqs4;
  logic [7:0] rdata4;
  logic [2:0] st4;
  logic       ready1, rsp1, scsn1, sclk1, mosi1, irqs1;
  logic [7:0] rdata1;
  logic [2:0] st1;

  logic       ready, rsp_valid, scsn, sclk, mosi;
  logic [7:0] rdata;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] f_mosi;
  int f_low, f_rises, f_rsp, f_ready_bad, f_rsp_bad, f_period_bad;
  logic [7:0] f_rdata;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  decred_spi_host #(.CLK_DIV(4)) u_dut4 (
    .CLK_IN             (clk),
    .EXT_RESET_N        (rst_n),
    .REQ_VALID          (req_valid & ~sel),
    .REQ_READY          (ready4),
    .REQ_WRITE          (req_write),
    .REQ_ADDR           (req_addr),
    .REQ_WDATA          (req_wdata),
    .RSP_VALID          (rsp4),
    .RSP_RDATA          (rdata4),
    .SCSN_toClient      (scsn4),
    .SCLK_toClient      (sclk4),
    .MOSI_toClient      (mosi4),
    .MISO_fromClient    (miso),
    .IRQ_OUT_fromClient (irq),
    .IRQ_SYNC           (irqs4),
    .state_dbg          (st4)
  );

  decred_spi_host #(.CLK_DIV(1)) u_dut1 (
    .CLK_IN             (clk),
    .EXT_RESET_N        (rst_n),
    .REQ_VALID          (req_valid & sel),
    .REQ_READY          (ready1),
    .REQ_WRITE          (req_write),
    .REQ_ADDR           (req_addr),
    .REQ_WDATA          (req_wdata),
    .RSP_VALID          (rsp1),
    .RSP_RDATA          (rdata1),
    .SCSN_toClient      (scsn1),
    .SCLK_toClient      (sclk1),
    .MOSI_toClient      (mosi1),
    .MISO_fromClient    (miso),
    .IRQ_OUT_fromClient (irq),
    .IRQ_SYNC           (irqs1),
    .state_dbg          (st1)
  );

  assign ready     = sel ? ready1 : ready4;
  assign rsp_valid = sel ? rsp1   : rsp4;
  assign scsn      = sel ? scsn1  : scsn4;
  assign sclk      = sel ? sclk1  : sclk4;
  assign mosi      = sel ? mosi1  : mosi4;
  assign rdata     = sel ? rdata1 : rdata4;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver + client model: issue one request, return {8'hC3, rx} on MISO, record pin activity.
  task automatic do_frame(input logic w, input logic [6:0] a, input logic [7:0] d,
                          input logic [7:0] rx);
    logic [15:0] cl;
    logic ps, pk;
    int last_rise;
    cl = {8'hC3, rx};
    @(negedge clk);
    req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
    for (int g = 0; g < 2000 && !ready; g++) @(negedge clk);
    check("accept_ready", 32'(ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0; req_write = ~w; req_addr = ~a; req_wdata = ~d;
    f_mosi = '0; f_low = 0; f_rises = 0; f_rsp = 0; f_rdata = '0;
    f_ready_bad = 0; f_rsp_bad = 0; f_period_bad = 0;
    ps = 1'b1; pk = 1'b0; last_rise = 0;
    for (int i = 0; i < 36 * cd + 4; i++) begin
      if (!scsn) begin
        f_low++;
        if (ready) f_ready_bad++;
      end
      if (sclk && !pk) begin
        if (f_rises > 0 && (i - last_rise) != 2 * cd) f_period_bad++;
        last_rise = i;
        f_rises++;
        f_mosi = {f_mosi[30:0], mosi};
      end
      if (rsp_valid) begin
        f_rsp++;
        f_rdata = rdata;
        if (!scsn || ps) f_rsp_bad++;
      end
      if (!scsn && ps) miso = cl[15];
      else if (!scsn && !sclk && pk) begin
        cl = {cl[14:0], 1'b0};
        miso = cl[15];
      end
      ps = scsn; pk = sclk;
      @(negedge clk);
    end
    miso = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [15:0] exp_mosi, input int exp_low,
                             input logic [7:0] exp_rdata);
    check({tag, "_mosi"},       f_mosi,              32'(exp_mosi));
    check({tag, "_scsn_low"},   32'(f_low),          32'(exp_low));
    check({tag, "_rises"},      32'(f_rises),        32'd16);
    check({tag, "_rsp_count"},  32'(f_rsp),          32'd1);
    check({tag, "_rdata"},      32'(f_rdata),        32'(exp_rdata));
    check({tag, "_ready_busy"}, 32'(f_ready_bad),    32'd0);
    check({tag, "_rsp_timing"}, 32'(f_rsp_bad),      32'd0);
    check({tag, "_sclk_period"},32'(f_period_bad),   32'd0);
  endtask

  initial begin
    logic ps, pk;
    logic [31:0] word;
    int rise1, fall2, rises, rsp_n, rbad, g;

    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    miso = 1'b0; irq = 1'b0; sel = 1'b0; cd = 4;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_scsn",  32'(scsn),      32'd1);
    check("rst_sclk",  32'(sclk),      32'd0);
    check("rst_mosi",  32'(mosi),      32'd0);
    check("rst_rsp",   32'(rsp_valid), 32'd0);
    check("rst_rdata", 32'(rdata),     32'h00);
    check("rst_irq",   32'(irqs4),     32'd0);
    check("rst_state", 32'(st4),       32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);

    // Write 0x12 <- 0xA5 : frame 0x92A5
    do_frame(1'b1, 7'h12, 8'hA5, 8'h5A);
    check_frame("wr12", 16'h92A5, 136, 8'h5A);

    // Read 0x05 (write data must be ignored) : frame 0x0500, client returns 0x3C
    do_frame(1'b0, 7'h05, 8'hFF, 8'h3C);
    check_frame("rd05", 16'h0500, 136, 8'h3C);

    // Back-to-back: write 0x01 <- 0x11 then read 0x02, REQ_VALID held
    @(negedge clk);
    req_write = 1'b1; req_addr = 7'h01; req_wdata = 8'h11; req_valid = 1'b1;
    for (int k = 0; k < 2000 && !ready; k++) @(negedge clk);
    check("b2b_accept", 32'(ready), 32'd1);
    @(negedge clk);
    req_write = 1'b0; req_addr = 7'h02; req_wdata = 8'h77;
    ps = 1'b0; pk = 1'b0; rise1 = -1; fall2 = -1; word = '0; rises = 0; rsp_n = 0; rbad = 0;
    for (int i = 0; i < 2 * (35 * 4 + 1) + 8; i++) begin
      if (!scsn && ready) rbad++;
      if (scsn && !ps && rise1 < 0) rise1 = i;
      if (!scsn && ps && rise1 >= 0 && fall2 < 0) begin
        fall2 = i;
        req_valid = 1'b0;
      end
      if (sclk && !pk) begin
        rises++;
        word = {word[30:0], mosi};
      end
      if (rsp_valid) rsp_n++;
      ps = scsn; pk = sclk;
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("b2b_gap",        32'(fall2 - rise1), 32'd5);
    check("b2b_rsp_count",  32'(rsp_n),         32'd2);
    check("b2b_rises",      32'(rises),         32'd32);
    check("b2b_mosi",       word,               32'h8111_0200);
    check("b2b_ready_busy", 32'(rbad),          32'd0);

    // Reset during bit period 6 of write 0x33 <- 0xCC (frame 0xB3CC, bit 9 = 1)
    @(negedge clk);
    req_write = 1'b1; req_addr = 7'h33; req_wdata = 8'hCC; req_valid = 1'b1;
    for (int k = 0; k < 2000 && !ready; k++) @(negedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rises = 0; pk = 1'b0; g = 0;
    while (rises < 7 && g < 400) begin
      @(negedge clk);
      g++;
      if (sclk && !pk) rises++;
      pk = sclk;
    end
    check("rstmid_reached", 32'(rises), 32'd7);
    check("rstmid_pre_mosi", 32'(mosi), 32'd1);
    check("rstmid_pre_sclk", 32'(sclk), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rstmid_scsn", 32'(scsn), 32'd1);
    check("rstmid_sclk", 32'(sclk), 32'd0);
    check("rstmid_mosi", 32'(mosi), 32'd0);
    rsp_n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rsp_valid) rsp_n++;
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_valid || !scsn) rsp_n++;
    end
    check("rstmid_no_rsp", 32'(rsp_n), 32'd0);
    check("rstmid_ready",  32'(ready), 32'd1);
    do_frame(1'b1, 7'h40, 8'h0F, 8'h81);
    check_frame("after_rst", 16'hC00F, 136, 8'h81);

    // IRQ synchronizer latency and reset
    @(negedge clk);
    #2 irq = 1'b1;
    @(negedge clk);
    check("irq_1cycle", 32'(irqs4), 32'd0);
    @(negedge clk);
    check("irq_2cycle", 32'(irqs4), 32'd1);
    #2 irq = 1'b0;
    @(negedge clk);
    check("irq_fall_1cycle", 32'(irqs4), 32'd1);
    @(negedge clk);
    check("irq_fall_2cycle", 32'(irqs4), 32'd0);
    irq = 1'b1;
    repeat (3) @(negedge clk);
    check("irq_high", 32'(irqs4), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("irq_reset", 32'(irqs4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    irq = 1'b0;
    @(negedge clk);

    // CLK_DIV=1 instance: reads returning 0xFF then 0x00
    sel = 1'b1; cd = 1;
    @(negedge clk);
    check("div1_idle_ready", 32'(ready), 32'd1);
    do_frame(1'b0, 7'h7F, 8'h00, 8'hFF);
    check_frame("div1_ff", 16'h7F00, 34, 8'hFF);
    do_frame(1'b0, 7'h7F, 8'hAA, 8'h00);
    check_frame("div1_00", 16'h7F00, 34, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
